dmem_responder: RTL

- Data-memory responder: the slave end of the CPU load/store path.
- Accepts one load or store request at a time and executes it against an internal 64-bit-wide RAM after a programmable latency.
- Load data is sized and sign/zero-extended per RV64 funct3 before it is returned.
- Replaces the single-cycle memory model so the core can be moved to a request/response memory interface.

---
 rtl/dmem_responder_pkg.sv | 45 ++++
 rtl/dmem_responder_if.sv | 37 +++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// ----------------------------------------------------------------------------
// dmem_responder_pkg
// Shared constants and helpers for the data-memory responder.
// - Access size codes taken from funct3[1:0] of RV64 load/store instructions.
// - FSM state encoding of the responder.
// - LOAD/STORE major opcodes used by the control decoder.
// - Size helpers: byte-lane mask and low-address alignment mask.
// ----------------------------------------------------------------------------
package dmem_responder_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size, starting at lane 0.
  function automatic logic [7:0] size_byte_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_lo_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Request/response bus between the CPU load/store unit (master) and the
// data-memory responder (slave).
//   req_valid/req_ready   request handshake
//   req_we                1 = store, 0 = load
//   req_funct3            RV64 load/store funct3
//   req_addr              byte address
//   req_wdata             store data (low bytes used per size)
//   resp_valid/resp_ready response handshake
//   resp_rdata            extended load data, 0 for stores and errors
//   resp_err              illegal funct3 or (optionally) misaligned access
// ----------------------------------------------------------------------------
interface dmem_responder_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Combinational byte-lane steering between a 64-bit RAM word and a sized
// load/store. The lane offset is the address forced to size alignment.
//   i_word       RAM word being read
//   i_wdata      raw store data (low bytes valid)
//   i_addr_lo    byte address bits [2:0]
//   i_funct3     RV64 load/store funct3
//   o_load_data  sized, sign/zero-extended load result
//   o_byte_en    byte enables for a store
//   o_store_data store data shifted into its byte lanes
// ----------------------------------------------------------------------------
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [63:0] i_word,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [63:0] o_load_data,
  output logic [7:0]  o_byte_en,
  output logic [63:0] o_store_data
);

  logic [1:0]  w_sz;
  logic [2:0]  w_off;
  logic [63:0] w_sh;

  assign w_sz  = i_funct3[1:0];
  // Clearing the sub-size bits keeps every access inside one word; when the
  // misalignment check is enabled the top flags such accesses as errors.
  assign w_off = i_addr_lo & ~size_lo_mask(w_sz);
  assign w_sh  = i_word >> {w_off, 3'b000};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    o_load_data = '0;
    case (w_sz)
      SZ_B: o_load_data = i_funct3[2] ? {56'b0, w_sh[7:0]}  : {{56{w_sh[7]}},  w_sh[7:0]};
      SZ_H: o_load_data = i_funct3[2] ? {48'b0, w_sh[15:0]} : {{48{w_sh[15]}}, w_sh[15:0]};
      SZ_W: o_load_data = i_funct3[2] ? {32'b0, w_sh[31:0]} : {{32{w_sh[31]}}, w_sh[31:0]};
      default: o_load_data = w_sh;
    endcase
  end

  assign o_byte_en    = size_byte_mask(w_sz) << w_off;
  assign o_store_data = i_wdata << {w_off, 3'b000};

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Slave end of the CPU load/store path. Accepts one request at a time, spends
// LATENCY cycles in ACCESS, then performs the RAM read (and read-modify-write
// for legal stores) and holds the response until it is consumed.
//   clk  clock, rst  asynchronous active-high reset
//   bus  dmem_responder_if.slave (request/response handshake)
// Parameters: DEPTH (64-bit words, power of two), LATENCY (>=1), ADDR_W.
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned accesses return
// resp_err=1, rdata=0 and never write. Without it, the low address bits are
// forced to size alignment and the access completes normally.
// ----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             r_state;
  state_t             w_next;
  logic               r_req_ready;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [IDX_W+2:0]   r_addr;
  logic [63:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [63:0]        r_rdata;
  logic               r_err;
  logic [63:0]        r_mem [DEPTH];

  logic               w_accept;
  logic               w_fire;
  logic               w_illegal;
  logic               w_err;
  logic               w_do_write;
  logic [IDX_W-1:0]   w_idx;
  logic [63:0]        w_word;
  logic [63:0]        w_load_data;
  logic [7:0]         w_byte_en;
  logic [63:0]        w_store_data;
  logic               w_unused_addr;

  // Upper address bits select nothing: the word index wraps modulo DEPTH.
  assign w_unused_addr = ^bus.req_addr[ADDR_W-1:IDX_W+3];

  assign w_accept = bus.req_valid && r_req_ready;
  assign w_fire   = (r_state == ST_ACCESS) && (r_cnt == '0);
  assign w_idx    = r_addr[IDX_W+2:3];
  assign w_word   = r_mem[w_idx];

  // Loads: only 111 is illegal. Stores: any funct3 with bit 2 set.
  assign w_illegal = r_we ? r_funct3[2] : (r_funct3 == 3'b111);

`ifdef DMEM_MISALIGN_CHECK_EN
  logic w_misaligned;
  assign w_misaligned = |(r_addr[2:0] & size_lo_mask(r_funct3[1:0]));
  assign w_err        = w_illegal | w_misaligned;
`else
  assign w_err        = w_illegal;
`endif

  assign w_do_write = w_fire && r_we && !w_err;

  dmem_lane_align u_lane_align (
    .i_word       (w_word),
    .i_wdata      (r_wdata),
    .i_addr_lo    (r_addr[2:0]),
    .i_funct3     (r_funct3),
    .o_load_data  (w_load_data),
    .o_byte_en    (w_byte_en),
    .o_store_data (w_store_data)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_ACCESS;
      ST_ACCESS: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP:   if (bus.resp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Registered ready: low through reset, rises on the first edge after.
      r_req_ready <= (w_next == ST_IDLE);
      if (w_accept) begin
        r_we     <= bus.req_we;
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr[IDX_W+2:0];
        r_wdata  <= bus.req_wdata;
        r_cnt    <= CNT_W'(LATENCY - 1);
      end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_fire) begin
        r_rdata <= (r_we || w_err) ? 64'd0 : w_load_data;
        r_err   <= w_err;
      end
    end
  end

  // NOTE: the RAM array has no reset; clearing it would prevent block-RAM
  // mapping, and contents are undefined after power-up anyway.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int b = 0; b < 8; b++) begin
        if (w_byte_en[b]) r_mem[w_idx][8*b +: 8] <= w_store_data[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule
